// File: rtl/alu_pkg.sv
// Shared encodings for the ALU datapath: operation select and the
// sequencing states of the digit-serial adder/subtractor.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle for digit_serial_addsub.
// slave is the adder side, master is the producer/consumer side.
interface digit_serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, in_a, in_b, in_c, op_sub, out_ready,
    output in_ready, out_valid, sum_out, c_out, overflow, zero
  );

  modport master (
    output in_valid, in_a, in_b, in_c, op_sub, out_ready,
    input  in_ready, out_valid, sum_out, c_out, overflow, zero
  );
endinterface

// File: rtl/digit_serial_addsub_adder.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry
// into its MSB so the caller can form signed overflow.
module digit_adder #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic [DIGIT:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[DIGIT];
    c_msb = c[DIGIT-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// WIDTH-bit add/subtract computed DIGIT bits per cycle, LSD first,
// through one shared ripple slice; registered sum and flags.
module digit_serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_serial_addsub_if.slave  bus
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout, slice_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = (bus.op_sub == OP_SUB) ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_c;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result digits enter at the top so after NDIG steps the LSD lands at bit 0.
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_cmsb;
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum_out   = sum_q;
  assign bus.c_out     = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub in three shapes:
// 32/8, 8/8 and 16/4 (WIDTH/DIGIT), checked against an arithmetic model.
module tb_digit_serial_addsub;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_drv [3];
  logic [31:0] b_drv [3];
  logic        c_drv [3];
  logic        sub_drv [3];
  logic        v_drv [3];
  logic        ordy [3];

  logic        rdy_o [3];
  logic        ovl_o [3];
  logic [31:0] sum_o [3];
  logic        cout_o [3];
  logic        ovf_o [3];
  logic        zero_o [3];

  function automatic int unsigned wid(input int unsigned id);
    return (id == 0) ? 32 : (id == 1) ? 8 : 16;
  endfunction

  function automatic int unsigned dig(input int unsigned id);
    return (id == 2) ? 4 : 8;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int unsigned W = (g == 0) ? 32 : (g == 1) ? 8 : 16;
    localparam int unsigned D = (g == 2) ? 4 : 8;

    digit_serial_addsub_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = v_drv[g];
    assign bus.in_a      = a_drv[g][W-1:0];
    assign bus.in_b      = b_drv[g][W-1:0];
    assign bus.in_c      = c_drv[g];
    assign bus.op_sub    = sub_drv[g];
    assign bus.out_ready = ordy[g];
    assign rdy_o[g]      = bus.in_ready;
    assign ovl_o[g]      = bus.out_valid;
    assign sum_o[g]      = 32'(bus.sum_out);
    assign cout_o[g]     = bus.c_out;
    assign ovf_o[g]      = bus.overflow;
    assign zero_o[g]     = bus.zero;

    digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  typedef struct {
    int unsigned id;
    logic [31:0] sum;
    logic        co;
    logic        ov;
    logic        z;
    int unsigned t;
    int unsigned lat;
  } exp_t;

  exp_t expq[$];
  bit   seen = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Plain modular arithmetic: signed overflow = operands share a sign the result lacks.
  function automatic exp_t model(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic sub, input int unsigned t);
    exp_t e;
    int unsigned w = wid(id);
    longint unsigned m  = (64'd1 << w) - 1;
    longint unsigned aa = 64'(a) & m;
    longint unsigned bb = 64'(sub ? ~b : b) & m;
    longint unsigned s  = aa + bb + 64'(c);
    longint unsigned sa = (aa >> (w - 1)) & 1;
    longint unsigned sb = (bb >> (w - 1)) & 1;
    longint unsigned ss = ((s & m) >> (w - 1)) & 1;
    e.id  = id;
    e.sum = 32'(s & m);
    e.co  = ((s >> w) & 1) != 0;
    e.ov  = (sa == sb) && (ss != sa);
    e.z   = (s & m) == 0;
    e.t   = t;
    e.lat = wid(id) / dig(id) + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (ovl_o[i]) begin
          if (expq.size() == 0 || expq[0].id != i) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out inst=%0d actual=valid required=no_result", i);
          end else begin
            if (!seen) begin
              check("latency", cyc - expq[0].t, expq[0].lat);
              seen = 1'b1;
            end
            check("sum", sum_o[i], expq[0].sum);
            check("c_out", 32'(cout_o[i]), 32'(expq[0].co));
            check("overflow", 32'(ovf_o[i]), 32'(expq[0].ov));
            check("zero", 32'(zero_o[i]), 32'(expq[0].z));
            if (ordy[i]) begin
              void'(expq.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  // Called mid-cycle (just after a rising edge); returns mid-cycle after the accept edge.
  task automatic issue(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic sub, input bit push,
                       output int unsigned t, output int unsigned n);
    a_drv[id]   = a;
    b_drv[id]   = b;
    c_drv[id]   = c;
    sub_drv[id] = sub;
    v_drv[id]   = 1'b1;
    n = 0;
    t = 0;
    while (!rdy_o[id]) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout inst=%0d actual=in_ready_low required=accept", id);
        v_drv[id] = 1'b0;
        return;
      end
    end
    t = cyc;
    if (push) expq.push_back(model(id, a, b, c, sub, t));
    @(posedge clk);
    #1;
    v_drv[id] = 1'b0;
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (expq.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_pending", 32'(expq.size()), 32'd0);
    expq.delete();
    seen = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        sub;
  } vec_t;

  vec_t dir [5] = '{
    '{32'h0000_00FF, 32'h0000_0001, 1'b0, OP_ADD},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD},
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD},
    '{32'h0000_0005, 32'h0000_0007, 1'b1, OP_SUB},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB}
  };

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, n, last_t, k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_drv[i] = '0; b_drv[i] = '0; c_drv[i] = 1'b0;
      sub_drv[i] = 1'b0; v_drv[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      check("reset_in_ready", 32'(rdy_o[i]), 32'd1);
      check("reset_out_valid", 32'(ovl_o[i]), 32'd0);
      check("reset_sum", sum_o[i], 32'd0);
      check("reset_flags", {29'd0, cout_o[i], ovf_o[i], zero_o[i]}, 32'd0);
    end

    foreach (dir[j]) begin
      issue(0, dir[j].a, dir[j].b, dir[j].c, dir[j].sub, 1'b1, t, n);
      drain();
    end

    // Backpressure: hold the result, poke in_valid, then release.
    ordy[0] = 1'b0;
    issue(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, OP_ADD, 1'b1, t, n);
    k = 0;
    while (!ovl_o[0] && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_reach_done", 32'(ovl_o[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", 32'(rdy_o[0]), 32'd0);
      a_drv[0] = $urandom;
      b_drv[0] = $urandom;
      v_drv[0] = 1'(i % 2);
      @(posedge clk);
      #1;
    end
    v_drv[0] = 1'b0;
    ordy[0]  = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_in_ready", 32'(rdy_o[0]), 32'd1);
    check("bp_idle_out_valid", 32'(ovl_o[0]), 32'd0);
    issue(0, 32'h0000_0010, 32'h0000_0020, 1'b0, OP_ADD, 1'b1, t, n);
    check("bp_accept_next", n, 32'd0);
    drain();

    // Reset while the digit counter is at 2: the operation must vanish.
    issue(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, OP_ADD, 1'b0, t, n);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_run_in_ready", 32'(rdy_o[0]), 32'd1);
    check("rst_run_out_valid", 32'(ovl_o[0]), 32'd0);
    check("rst_run_sum", sum_o[0], 32'd0);
    check("rst_run_flags", {29'd0, cout_o[0], ovf_o[0], zero_o[0]}, 32'd0);
    issue(0, 32'd3, 32'd4, 1'b0, OP_ADD, 1'b1, t, n);
    drain();

    // Single-digit configuration.
    issue(1, 32'h7F, 32'h01, 1'b0, OP_ADD, 1'b1, t, n);
    drain();
    issue(1, 32'hFF, 32'h01, 1'b0, OP_ADD, 1'b1, t, n);
    drain();

    // Random ops on 16/4, back-to-back with the consumer always ready.
    last_t = 0;
    for (int i = 0; i < 30; i++) begin
      issue(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, t, n);
      if (i > 0) check("throughput", t - last_t, 32'd6);
      last_t = t;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
